// File: rtl/game_timer_pkg.sv
// Shared types and defaults for the countdown game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    StArmed,
    StRunning,
    StPaused,
    StExpired
  } state_e;

  localparam int unsigned GT_DEFAULT_SECONDS = 60;
  localparam int unsigned GT_MAX_SECONDS     = 99;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/game_timer_if.sv
// Controller <-> game timer link: load/run controls in, timeout and BCD digits out.
interface game_timer_if
  import game_timer_pkg::*;
();

  logic       reconfig;
  logic       enable;
  logic [6:0] time_in;
  logic       timeout;
  logic       running;
  bcd_t       tens;
  bcd_t       ones;

  modport master (
    output reconfig, enable, time_in,
    input  timeout, running, tens, ones
  );

  modport slave (
    input  reconfig, enable, time_in,
    output timeout, running, tens, ones
  );

endinterface

// File: rtl/game_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles; holds when not enabled.
module game_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = count_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Countdown game timer: loads a clamped duration on reconfig, counts down BCD seconds while enabled.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEFAULT_SECONDS = GT_DEFAULT_SECONDS,
  parameter int unsigned MAX_SECONDS     = GT_MAX_SECONDS
) (
  input logic        clk,
  input logic        reset,
  game_timer_if.slave bus
);

  localparam logic [6:0] DEF_VAL = 7'(DEFAULT_SECONDS);
  localparam logic [6:0] MAX_VAL = 7'(MAX_SECONDS);

  // Clamp the switch value and split it into {tens, ones}.
  function automatic logic [7:0] load_bcd(input logic [6:0] t);
    logic [6:0] v;
    if (t == 7'd0) begin
      v = DEF_VAL;
    end else if (t > MAX_VAL) begin
      v = MAX_VAL;
    end else begin
      v = t;
    end
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  state_e state_q, state_d;
  bcd_t   tens_q, tens_d;
  bcd_t   ones_q, ones_d;
  logic   presc_clear;
  logic   count_en;
  logic   tick;

  // Frozen while a reconfig is being taken so the restart begins from zero.
  assign count_en = (state_q == StRunning) && !bus.reconfig;

  game_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (presc_clear),
    .count_en (count_en),
    .tick     (tick)
  );

  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    presc_clear = 1'b0;
    if (bus.reconfig) begin
      {tens_d, ones_d} = load_bcd(bus.time_in);
      presc_clear      = 1'b1;
      state_d          = StArmed;
    end else begin
      unique case (state_q)
        StArmed: begin
          if (bus.enable) begin
            state_d     = StRunning;
            presc_clear = 1'b1;
          end
        end
        StRunning: begin
          if (tick && tens_q == 4'd0 && ones_q == 4'd1) begin
            ones_d  = 4'd0;
            state_d = StExpired;
          end else begin
            if (tick) begin
              if (ones_q != 4'd0) begin
                ones_d = ones_q - 4'd1;
              end else if (tens_q != 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end
            end
            if (!bus.enable) begin
              state_d = StPaused;
            end
          end
        end
        StPaused: begin
          if (bus.enable) begin
            state_d = StRunning;
          end
        end
        StExpired: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= StArmed;
      {tens_q, ones_q} <= load_bcd(7'd0);
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.timeout = (state_q == StExpired);
  assign bus.running = (state_q == StRunning);
  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;

endmodule
